ofs_fim_axis_pkt_arb: RTL and testbench

Packet-aware N:1 AXI-Stream arbiter with a registered output stage. It merges several AXIS sources, such as per-function TX streams, into one stream that feeds the FIM AXIS pipeline register and PCIe SS TX path. Arbitration is round-robin at packet granularity: once a source wins, it keeps the output until its tlast beat is accepted. Beats from different sources are never interleaved.

---
 rtl/ofs_pcie_ss_cfg_pkg.sv | 17 +
 rtl/ofs_fim_axis_arb_rr_pick.sv | 49 ++++
 rtl/ofs_fim_axis_pkt_arb.sv | 167 ++++++++++++++++
 tb/tb_ofs_fim_axis_pkt_arb.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_pcie_ss_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ofs_pcie_ss_cfg_pkg
//
// Purpose: shared PCIe subsystem stream configuration. Blocks on the FIM AXIS
// TX path take their default payload widths from here so that one edit
// retargets the whole datapath.
//
// Contents:
//   TDATA_WIDTH  AXIS tdata width in bits
//   TUSER_WIDTH  AXIS tuser width in bits
// ---------------------------------------------------------------------------
package ofs_pcie_ss_cfg_pkg;

    localparam int TDATA_WIDTH = 512;
    localparam int TUSER_WIDTH = 10;

endpackage : ofs_pcie_ss_cfg_pkg

// File: rtl/ofs_fim_axis_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// ofs_fim_axis_arb_rr_pick
//
// Purpose: combinational round-robin picker. Returns the first requester
// found when searching from rr_ptr upwards, wrapping modulo NUM_INPUTS.
// NUM_INPUTS need not be a power of two.
//
// Ports:
//   req        in   NUM_INPUTS  request vector
//   rr_ptr     in   SRC_WIDTH   highest-priority index (must be < NUM_INPUTS)
//   grant      out  NUM_INPUTS  one-hot grant (all zero when no request)
//   grant_idx  out  SRC_WIDTH   index of the granted requester (0 when none)
//   any_grant  out  1           at least one request is present
// ---------------------------------------------------------------------------
module ofs_fim_axis_arb_rr_pick #(
    parameter int NUM_INPUTS = 2,
    parameter int SRC_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [SRC_WIDTH-1:0]  rr_ptr,
    output logic [NUM_INPUTS-1:0] grant,
    output logic [SRC_WIDTH-1:0]  grant_idx,
    output logic                  any_grant
);

    always_comb begin
        int                   p;
        logic [SRC_WIDTH-1:0] idx;
        p         = 0;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int off = 0; off < NUM_INPUTS; off++) begin
            // Explicit wrap instead of a modulo so non-power-of-two counts work.
            p = int'(rr_ptr) + off;
            if (p >= NUM_INPUTS) begin
                p = p - NUM_INPUTS;
            end
            idx = SRC_WIDTH'(p);
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule : ofs_fim_axis_arb_rr_pick

// File: rtl/ofs_fim_axis_pkt_arb.sv
// ---------------------------------------------------------------------------
// ofs_fim_axis_pkt_arb
//
// Purpose: packet-aware N:1 AXI-Stream arbiter with a registered output
// stage. Round-robin at packet granularity: a winning source keeps the output
// until its tlast beat is accepted, so packets are never interleaved.
//
// Ports:
//   clk       in   1                        clock, all logic on posedge
//   rst       in   1                        synchronous active-high reset
//   s_tvalid  in   NUM_INPUTS               per-source valid
//   s_tready  out  NUM_INPUTS               per-source ready (at most one set)
//   s_tdata   in   NUM_INPUTS*TDATA_WIDTH   source i at [i*TDATA_WIDTH +: TDATA_WIDTH]
//   s_tkeep   in   NUM_INPUTS*TKEEP_WIDTH   same packing
//   s_tlast   in   NUM_INPUTS               end of packet
//   s_tuser   in   NUM_INPUTS*TUSER_WIDTH   same packing
//   m_tready  in   1                        downstream ready
//   m_tvalid  out  1                        registered output valid
//   m_tdata/m_tkeep/m_tlast/m_tuser  out    registered payload
//   m_tsrc    out  SRC_WIDTH                source index of the current beat
//
// s_tready is combinational from m_tready, s_tvalid and state.
// ---------------------------------------------------------------------------
module ofs_fim_axis_pkt_arb #(
    parameter int NUM_INPUTS  = 2,
    parameter int TDATA_WIDTH = ofs_pcie_ss_cfg_pkg::TDATA_WIDTH,
    parameter int TUSER_WIDTH = ofs_pcie_ss_cfg_pkg::TUSER_WIDTH,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int SRC_WIDTH   = $clog2(NUM_INPUTS)
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic [NUM_INPUTS-1:0]             s_tvalid,
    output logic [NUM_INPUTS-1:0]             s_tready,
    input  logic [NUM_INPUTS*TDATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_INPUTS*TKEEP_WIDTH-1:0] s_tkeep,
    input  logic [NUM_INPUTS-1:0]             s_tlast,
    input  logic [NUM_INPUTS*TUSER_WIDTH-1:0] s_tuser,

    input  logic                              m_tready,
    output logic                              m_tvalid,
    output logic [TDATA_WIDTH-1:0]            m_tdata,
    output logic [TKEEP_WIDTH-1:0]            m_tkeep,
    output logic                              m_tlast,
    output logic [TUSER_WIDTH-1:0]            m_tuser,
    output logic [SRC_WIDTH-1:0]              m_tsrc
);

    typedef enum logic {
        StUnlocked = 1'b0,
        StLocked   = 1'b1
    } lock_state_e;

    lock_state_e           state_q, state_d;
    logic [SRC_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SRC_WIDTH-1:0]  lock_idx_q, lock_idx_d;

    logic [NUM_INPUTS-1:0] pick_grant;
    logic [SRC_WIDTH-1:0]  pick_idx;
    logic                  pick_any;

    logic [NUM_INPUTS-1:0] grant;
    logic [SRC_WIDTH-1:0]  grant_idx;
    logic                  grant_valid;
    logic                  adv;
    logic                  accept;

    // Index of the source after k, wrapping at NUM_INPUTS.
    function automatic logic [SRC_WIDTH-1:0] next_ptr(input logic [SRC_WIDTH-1:0] k);
        if (int'(k) + 1 == NUM_INPUTS) begin
            return '0;
        end
        return k + SRC_WIDTH'(1);
    endfunction

    ofs_fim_axis_arb_rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .SRC_WIDTH  (SRC_WIDTH)
    ) u_rr_pick (
        .req       (s_tvalid),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_grant (pick_any)
    );

    assign adv = ~m_tvalid | m_tready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StUnlocked;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            if (s_tlast[grant_idx]) begin
                // Packet done: release and hand priority to the next source.
                state_d  = StUnlocked;
                rr_ptr_d = next_ptr(grant_idx);
            end else begin
                state_d    = StLocked;
                lock_idx_d = grant_idx;
            end
        end
    end

    // While locked the owner keeps the grant even with tvalid low, so a
    // source stalling mid-packet blocks everyone else rather than interleave.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        unique case (state_q)
            StUnlocked: begin
                grant       = pick_grant;
                grant_idx   = pick_idx;
                grant_valid = pick_any;
            end
            StLocked: begin
                grant[lock_idx_q] = 1'b1;
                grant_idx         = lock_idx_q;
                grant_valid       = 1'b1;
            end
            default: begin
                grant       = '0;
                grant_idx   = '0;
                grant_valid = 1'b0;
            end
        endcase
    end

    assign s_tready = (adv && !rst) ? grant : '0;
    assign accept   = grant_valid & adv & ~rst & s_tvalid[grant_idx];

    // ------------------------------------------------------- output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
        end else if (adv) begin
            m_tvalid <= accept;
        end
    end

    // Payload is qualified by m_tvalid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (adv) begin
            m_tdata <= s_tdata[grant_idx*TDATA_WIDTH +: TDATA_WIDTH];
            m_tkeep <= s_tkeep[grant_idx*TKEEP_WIDTH +: TKEEP_WIDTH];
            m_tuser <= s_tuser[grant_idx*TUSER_WIDTH +: TUSER_WIDTH];
            m_tlast <= s_tlast[grant_idx];
            m_tsrc  <= grant_idx;
        end
    end

endmodule : ofs_fim_axis_pkt_arb

// File: tb/tb_ofs_fim_axis_pkt_arb.sv
// ---------------------------------------------------------------------------
// tb_ofs_fim_axis_pkt_arb
//
// Purpose: self-checking bench for ofs_fim_axis_pkt_arb with three sources.
// Per-source drivers replay beat queues (bubble entries model idle cycles);
// each test pushes the hand-derived output order into a scoreboard queue and
// an independent negedge monitor pops and compares every output transfer.
// ---------------------------------------------------------------------------
module tb_ofs_fim_axis_pkt_arb;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int UW = 8;
    localparam int KW = DW / 8;
    localparam int SW = $clog2(N);

    typedef struct packed {
        logic          vld;
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N-1:0]    s_tlast;
    logic [N*UW-1:0] s_tuser;
    logic            m_tready;
    logic            m_tvalid;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [UW-1:0]   m_tuser;
    logic [SW-1:0]   m_tsrc;

    ofs_fim_axis_pkt_arb #(
        .NUM_INPUTS  (N),
        .TDATA_WIDTH (DW),
        .TUSER_WIDTH (UW),
        .TKEEP_WIDTH (KW),
        .SRC_WIDTH   (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tuser  (s_tuser),
        .m_tready (m_tready),
        .m_tvalid (m_tvalid),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tuser  (m_tuser),
        .m_tsrc   (m_tsrc)
    );

    always #5 clk = ~clk;

    beat_t srcq [N][$];
    beat_t exp_q[$];
    bit    shown  [N];
    int    acc_cnt[N];
    logic [N-1:0] acc_n = '0;
    bit    bp_en = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    int pops_mark = 0;
    int first_pop = 0;
    int last_pop  = 0;

    function automatic beat_t mk(input int src, input int tag, input bit last);
        beat_t b;
        b.vld  = 1'b1;
        b.src  = SW'(src);
        b.data = 32'h5A00_0000 | (32'(src) << 16) | 32'(tag);
        b.keep = last ? 4'h3 : 4'hF;
        b.last = last;
        b.user = 8'(tag) ^ 8'(src * 16);
        return b;
    endfunction

    function automatic beat_t bubble();
        beat_t b;
        b     = '0;
        b.vld = 1'b0;
        return b;
    endfunction

    // Queue an nbeat packet on a source; tags run tag, tag+1, ...
    task automatic send_pkt(input int src, input int tag, input int nbeats);
        for (int b = 0; b < nbeats; b++) srcq[src].push_back(mk(src, tag + b, b == nbeats - 1));
    endtask

    task automatic expect_pkt(input int src, input int tag, input int nbeats);
        for (int b = 0; b < nbeats; b++) exp_q.push_back(mk(src, tag + b, b == nbeats - 1));
    endtask

    function automatic bit src_busy();
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic reset_begin();
        @(posedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            shown[i] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic reset_end();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int b;
        b = budget;
        while ((exp_q.size() != 0 || src_busy()) && b > 0) begin
            @(posedge clk);
            b--;
        end
        if (exp_q.size() != 0 || src_busy()) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s drain: %0d expected beats outstanding, required 0", name,
                     exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // --------------------------------------------------------- source drivers
    initial begin
        beat_t cur;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (shown[i] && srcq[i].size() > 0) begin
                    if (!srcq[i][0].vld) begin
                        void'(srcq[i].pop_front());
                    end else if (acc_n[i]) begin
                        void'(srcq[i].pop_front());
                        acc_cnt[i]++;
                    end
                end
                if (srcq[i].size() > 0) begin
                    cur                  = srcq[i][0];
                    s_tvalid[i]          = cur.vld;
                    s_tdata[i*DW +: DW]  = cur.data;
                    s_tkeep[i*KW +: KW]  = cur.keep;
                    s_tlast[i]           = cur.last;
                    s_tuser[i*UW +: UW]  = cur.user;
                    shown[i]             = 1'b1;
                end else begin
                    s_tvalid[i] = 1'b0;
                    shown[i]    = 1'b0;
                end
            end
            m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------------------------------------------------------- monitor
    initial begin
        logic [SW+DW+KW+1+UW-1:0] out_now, out_held;
        bit    stalled;
        beat_t got, e;
        stalled  = 1'b0;
        out_held = '0;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            acc_n   = s_tvalid & s_tready;
            out_now = {m_tsrc, m_tdata, m_tkeep, m_tlast, m_tuser};
            if (stalled && !rst) begin
                n_cmp++;
                if (out_now !== out_held) begin
                    n_fail++;
                    $display("FAIL stall_hold: output %h changed, required %h", out_now, out_held);
                end
            end
            stalled  = !rst && (m_tvalid === 1'b1) && !m_tready;
            out_held = out_now;
            if (!rst && m_tvalid === 1'b1 && m_tready) begin
                n_cmp++;
                got = '{vld: 1'b1, src: m_tsrc, data: m_tdata, keep: m_tkeep,
                        last: m_tlast, user: m_tuser};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard: unexpected beat %h, required none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL scoreboard: got beat %h, required %h", got, e);
                    end
                end
                if (pops_mark == 0) first_pop = cyc_cnt;
                last_pop = cyc_cnt;
                pops_mark++;
            end
        end
    end

    task automatic check_span(input string name, input int want);
        n_cmp++;
        if (last_pop - first_pop != want) begin
            n_fail++;
            $display("FAIL %s span: %0d cycles first-to-last beat, required %0d", name,
                     last_pop - first_pop, want);
        end
    endtask

    // ------------------------------------------------------------------ tests
    initial begin
        int base;
        int budget;

        // Reset: all sources valid during a 4-cycle reset.
        rst = 1'b1;
        for (int i = 0; i < N; i++) send_pkt(i, 8'h01, 1);
        for (int i = 0; i < N; i++) expect_pkt(i, 8'h01, 1);
        repeat (4) begin
            @(negedge clk);
            n_cmp += 2;
            if (s_tready !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_tready: s_tready %b, required 000", s_tready);
            end
            if (m_tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_tvalid: m_tvalid %b, required 0", m_tvalid);
            end
        end
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_tready !== 3'b001) begin
            n_fail++;
            $display("FAIL first_grant: s_tready %b, required 001", s_tready);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (m_tvalid !== 1'b1 || m_tsrc !== 2'd0) begin
            n_fail++;
            $display("FAIL first_beat: m_tvalid %b m_tsrc %0d, required 1 and 0", m_tvalid,
                     m_tsrc);
        end
        drain("reset", 50);

        // Lock: src0 single, src1 4-beat, src2 single, src0 single.
        reset_begin();
        send_pkt(0, 8'h10, 1);
        send_pkt(0, 8'h11, 1);
        send_pkt(1, 8'h20, 4);
        send_pkt(2, 8'h30, 1);
        expect_pkt(0, 8'h10, 1);
        expect_pkt(1, 8'h20, 4);
        expect_pkt(2, 8'h30, 1);
        expect_pkt(0, 8'h11, 1);
        pops_mark = 0;
        reset_end();
        drain("lock", 60);
        check_span("lock", 6);

        // Wrap: every source streams single-beat packets.
        reset_begin();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                send_pkt(i, 8'h40 + r, 1);
                expect_pkt(i, 8'h40 + r, 1);
            end
        end
        pops_mark = 0;
        reset_end();
        drain("wrap", 60);
        check_span("wrap", 5);

        // Backpressure: two sources, 2-beat packets, random m_tready.
        reset_begin();
        for (int p = 0; p < 3; p++) begin
            send_pkt(0, 8'h50 + 4 * p, 2);
            send_pkt(1, 8'h70 + 4 * p, 2);
            expect_pkt(0, 8'h50 + 4 * p, 2);
            expect_pkt(1, 8'h70 + 4 * p, 2);
        end
        bp_en = 1'b1;
        reset_end();
        drain("backpressure", 400);
        bp_en = 1'b0;
        repeat (2) @(posedge clk);

        // Idle lock: src0 stalls mid-packet for 5 cycles; src1 must wait.
        reset_begin();
        srcq[0].push_back(mk(0, 8'h90, 1'b0));
        repeat (5) srcq[0].push_back(bubble());
        srcq[0].push_back(mk(0, 8'h91, 1'b1));
        send_pkt(1, 8'hA0, 1);
        expect_pkt(0, 8'h90, 2);
        expect_pkt(1, 8'hA0, 1);
        base = acc_cnt[0];
        reset_end();
        budget = 40;
        while (acc_cnt[0] - base < 2 && budget > 0) begin
            @(negedge clk);
            n_cmp++;
            if (s_tready[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_lock: s_tready[1] %b while src0 packet open, required 0",
                         s_tready[1]);
            end
            budget--;
            @(posedge clk); #2;
        end
        if (budget == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_lock: src0 tlast not accepted, %0d of 2 beats", acc_cnt[0] - base);
        end
        drain("idle_lock", 40);

        // Reset mid-packet: src1 single moves rr_ptr to 2, then src2 4-beat
        // packet is cut by reset while beat 2 is presented.
        reset_begin();
        send_pkt(1, 8'hB0, 1);
        send_pkt(2, 8'hC0, 4);
        expect_pkt(1, 8'hB0, 1);
        base = acc_cnt[2];
        reset_end();
        budget = 20;
        while (acc_cnt[2] == base && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL mid_reset: src2 first beat not accepted, required 1 beat");
        end
        rst = 1'b1;
        @(posedge clk); #2;
        n_cmp++;
        if (m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_tvalid: m_tvalid %b, required 0", m_tvalid);
        end
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            shown[i] = 1'b0;
        end
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            send_pkt(i, 8'hD0, 1);
            expect_pkt(i, 8'hD0, 1);
        end
        @(posedge clk); #2 rst = 1'b0;
        drain("mid_reset", 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_ofs_fim_axis_pkt_arb
